// File: rtl/rv32m_pkg.sv
// Shared definitions for the RV32M iterative multiply/divide unit:
// funct3 encodings, FSM state encoding and special-result constants.
package rv32m_pkg;

    // Only a 32-bit datapath is supported.
    localparam int RV_XLEN = 32;

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [RV_XLEN-1:0] INT_MIN  = 32'h8000_0000;
    localparam logic [RV_XLEN-1:0] ALL_ONES = 32'hFFFF_FFFF;

    function automatic logic is_div(input logic [2:0] op);
        return op[2];
    endfunction

endpackage

// File: rtl/rv32m_muldiv_unit_if.sv
// Request/response bundle between the execute stage (master) and the
// multiply/divide unit (slave).
interface rv32m_muldiv_unit_if #(
    parameter int XLEN = 32
);
    // Both ports are valid/ready: a transfer happens on a rising edge where
    // valid && ready; the sender holds its payload until then. flush in the
    // same cycle as an IDLE request suppresses that acceptance.
    logic            in_valid;
    logic            in_ready;
    logic [2:0]      op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            busy;

    modport master (
        output in_valid, op, a, b, flush, out_ready,
        input  in_ready, out_valid, result, busy
    );

    modport slave (
        input  in_valid, op, a, b, flush, out_ready,
        output in_ready, out_valid, result, busy
    );
endinterface

// File: rtl/rv32m_sign_cond.sv
// Sign conditioning around the unsigned iterative core: operand magnitudes
// and result-sign flag on the way in, conditional negation on the way out.
module rv32m_sign_cond
    import rv32m_pkg::*;
#(
    parameter int XLEN = RV_XLEN
) (
    input  logic [2:0]        op_i,
    input  logic [XLEN-1:0]   a_i,
    input  logic [XLEN-1:0]   b_i,
    output logic [XLEN-1:0]   abs_a_o,
    output logic [XLEN-1:0]   abs_b_o,
    output logic              neg_o,
    input  logic [2:0]        op_q_i,
    input  logic              neg_q_i,
    input  logic [2*XLEN-1:0] acc_i,
    output logic [XLEN-1:0]   res_o
);

    logic              a_signed;
    logic              b_signed;
    logic              a_neg;
    logic              b_neg;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo;
    logic [XLEN-1:0]   rem;

    always_comb begin
        a_signed = 1'b0;
        b_signed = 1'b0;
        case (op_i)
            OP_MUL, OP_MULH, OP_DIV, OP_REM: begin
                a_signed = 1'b1;
                b_signed = 1'b1;
            end
            OP_MULHSU: a_signed = 1'b1;
            default: ;
        endcase
        a_neg   = a_signed & a_i[XLEN-1];
        b_neg   = b_signed & b_i[XLEN-1];
        abs_a_o = a_neg ? -a_i : a_i;
        abs_b_o = b_neg ? -b_i : b_i;
        // Remainder takes the dividend's sign; everything else the XOR.
        neg_o   = (op_i == OP_REM) ? a_neg : (a_neg ^ b_neg);
    end

    always_comb begin
        prod = neg_q_i ? -acc_i : acc_i;
        quo  = neg_q_i ? -acc_i[XLEN-1:0] : acc_i[XLEN-1:0];
        rem  = neg_q_i ? -acc_i[2*XLEN-1:XLEN] : acc_i[2*XLEN-1:XLEN];
        case (op_q_i)
            OP_MUL:                     res_o = prod[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: res_o = prod[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:            res_o = quo;
            default:                    res_o = rem;
        endcase
    end

endmodule

// File: rtl/rv32m_muldiv_unit.sv
// Iterative RV32M multiply/divide unit: 32 shift-add or restoring-divide
// steps per op over a shared 64-bit accumulator, one op in flight.
module rv32m_muldiv_unit
    import rv32m_pkg::*;
#(
    parameter int XLEN = RV_XLEN
) (
    input  logic                      clk,
    input  logic                      rst,
    rv32m_muldiv_unit_if.slave        bus,
    output state_t                    dbg_state_o
);

    localparam int CNT_W = $clog2(XLEN);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        op_q, op_d;
    logic              neg_q, neg_d;
    logic [XLEN-1:0]   opnd_q, opnd_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   result_q, result_d;

    logic [XLEN-1:0]   abs_a;
    logic [XLEN-1:0]   abs_b;
    logic              pre_neg;
    logic [XLEN-1:0]   post_res;
    logic [2*XLEN-1:0] acc_step;
    logic [XLEN:0]     add_sum;
    logic [XLEN:0]     div_trial;
    logic [XLEN:0]     div_diff;
    logic              div_zero;
    logic              div_ovf;
    logic [XLEN-1:0]   special_res;

    rv32m_sign_cond #(.XLEN(XLEN)) u_sign_cond (
        .op_i    (bus.op),
        .a_i     (bus.a),
        .b_i     (bus.b),
        .abs_a_o (abs_a),
        .abs_b_o (abs_b),
        .neg_o   (pre_neg),
        .op_q_i  (op_q),
        .neg_q_i (neg_q),
        .acc_i   (acc_step),
        .res_o   (post_res)
    );

    // acc holds {high, low}: multiplier/product or remainder/quotient.
    always_comb begin
        add_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, opnd_q};
        div_trial = acc_q[2*XLEN-1:XLEN-1];
        div_diff  = div_trial - {1'b0, opnd_q};
        if (is_div(op_q)) begin
            if (!div_diff[XLEN]) acc_step = {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
            else                 acc_step = {acc_q[2*XLEN-2:0], 1'b0};
        end else if (acc_q[0]) begin
            acc_step = {add_sum, acc_q[XLEN-1:1]};
        end else begin
            acc_step = {1'b0, acc_q[2*XLEN-1:1]};
        end
    end

    always_comb begin
        div_zero    = is_div(bus.op) && (bus.b == '0);
        div_ovf     = ((bus.op == OP_DIV) || (bus.op == OP_REM)) &&
                      (bus.a == INT_MIN) && (bus.b == ALL_ONES);
        if (bus.op[1]) special_res = div_zero ? bus.a : '0;
        else           special_res = div_zero ? ALL_ONES : INT_MIN;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        neg_d    = neg_q;
        opnd_d   = opnd_q;
        acc_d    = acc_q;
        result_d = result_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid && !bus.flush) begin
                    op_d   = bus.op;
                    neg_d  = pre_neg;
                    opnd_d = abs_b;
                    acc_d  = {{XLEN{1'b0}}, abs_a};
                    cnt_d  = '0;
                    if (div_zero || div_ovf) begin
                        state_d  = ST_DONE;
                        result_d = special_res;
                    end else begin
                        state_d  = ST_CALC;
                    end
                end
            end
            ST_CALC: begin
                if (bus.flush) begin
                    state_d = ST_IDLE;
                end else begin
                    acc_d = acc_step;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(XLEN - 1)) begin
                        state_d  = ST_DONE;
                        result_d = post_res;
                    end
                end
            end
            ST_DONE: begin
                if (bus.flush || bus.out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            neg_q    <= 1'b0;
            opnd_q   <= '0;
            acc_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            neg_q    <= neg_d;
            opnd_q   <= opnd_d;
            acc_q    <= acc_d;
            result_q <= result_d;
        end
    end

    assign bus.in_ready  = (state_q == ST_IDLE);
    assign bus.out_valid = (state_q == ST_DONE);
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.result    = result_q;
    assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_rv32m_muldiv_unit.sv
// Directed bench for rv32m_muldiv_unit: multiply/divide vectors, special
// cases, backpressure, back-to-back, flush and reset aborts.
module tb_rv32m_muldiv_unit;
    import rv32m_pkg::*;

    logic   clk;
    logic   rst;
    state_t dbg_state;
    int     n_vec;
    int     n_err;
    logic [31:0] exp_q[$];

    rv32m_muldiv_unit_if #(.XLEN(32)) bus ();

    rv32m_muldiv_unit #(.XLEN(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .dbg_state_o (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Caller sits just after a negedge; returns just after the negedge
    // following the accept edge, with request inputs scrambled.
    task automatic send_req(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.in_valid = 1'b1;
        bus.op       = op;
        bus.a        = a;
        bus.b        = b;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.op       = 3'($urandom_range(0, 7));
        bus.a        = $urandom();
        bus.b        = $urandom();
    endtask

    task automatic wait_result(output int lat, output logic [31:0] res, output bit hs_ok);
        lat   = 1;
        hs_ok = 1'b1;
        while (bus.out_valid !== 1'b1 && lat < 100) begin
            if (bus.in_ready !== 1'b0 || bus.busy !== 1'b1) hs_ok = 1'b0;
            @(negedge clk);
            lat++;
        end
        res = bus.result;
    endtask

    task automatic consume();
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        bus.in_valid  = 1'b0;
        bus.op        = '0;
        bus.a         = '0;
        bus.b         = '0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        n_vec++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL reset out_valid: got %b want 0", bus.out_valid); end
        n_vec++; if (bus.result !== 32'h0) begin n_err++; $display("FAIL reset result: got %h want 00000000", bus.result); end
        n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL reset busy: got %b want 0", bus.busy); end
        n_vec++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL reset in_ready: got %b want 1", bus.in_ready); end
        n_vec++; if (dbg_state !== ST_IDLE) begin n_err++; $display("FAIL reset state: got %0d want %0d", dbg_state, ST_IDLE); end
    endtask

    task automatic test_mul();
        logic [2:0]  ops [7];
        logic [31:0] va  [7];
        logic [31:0] vb  [7];
        logic [31:0] ve  [7];
        logic [31:0] res, exp;
        int          lat;
        bit          hs_ok;
        ops = '{OP_MUL, OP_MULH, OP_MULHU, OP_MULHSU, OP_MUL, OP_MULH, OP_MULHU};
        va  = '{32'h0000_0007, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1234_5678};
        vb  = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0010};
        ve  = '{32'hFFFF_FFEB, 32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0001};
        for (int i = 0; i < 7; i++) begin
            exp_q.push_back(ve[i]);
            send_req(ops[i], va[i], vb[i]);
            wait_result(lat, res, hs_ok);
            exp = exp_q.pop_front();
            n_vec++; if (res !== exp) begin n_err++; $display("FAIL mul[%0d] result: got %h want %h", i, res, exp); end
            n_vec++; if (lat !== 33) begin n_err++; $display("FAIL mul[%0d] latency: got %0d want 33", i, lat); end
            n_vec++; if (hs_ok !== 1'b1) begin n_err++; $display("FAIL mul[%0d] in_ready/busy during calc: got bad want in_ready=0 busy=1", i); end
            consume();
            n_vec++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL mul[%0d] in_ready after take: got %b want 1", i, bus.in_ready); end
        end
    endtask

    task automatic test_div();
        logic [2:0]  ops [7];
        logic [31:0] va  [7];
        logic [31:0] vb  [7];
        logic [31:0] ve  [7];
        logic [31:0] res, exp;
        int          lat;
        bit          hs_ok;
        ops = '{OP_DIV, OP_REM, OP_DIVU, OP_REMU, OP_DIV, OP_REM, OP_DIVU};
        va  = '{32'hFFFF_FFEC, 32'hFFFF_FFEC, 32'd20, 32'd20, 32'd20, 32'd20, 32'hFFFF_FFFF};
        vb  = '{32'd7, 32'd7, 32'd7, 32'd7, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd1};
        ve  = '{32'hFFFF_FFFE, 32'hFFFF_FFFA, 32'd2, 32'd6, 32'hFFFF_FFFE, 32'd6, 32'hFFFF_FFFF};
        for (int i = 0; i < 7; i++) begin
            exp_q.push_back(ve[i]);
            send_req(ops[i], va[i], vb[i]);
            wait_result(lat, res, hs_ok);
            exp = exp_q.pop_front();
            n_vec++; if (res !== exp) begin n_err++; $display("FAIL div[%0d] result: got %h want %h", i, res, exp); end
            n_vec++; if (lat !== 33) begin n_err++; $display("FAIL div[%0d] latency: got %0d want 33", i, lat); end
            n_vec++; if (hs_ok !== 1'b1) begin n_err++; $display("FAIL div[%0d] in_ready/busy during calc: got bad want in_ready=0 busy=1", i); end
            consume();
        end
    endtask

    task automatic test_special();
        logic [2:0]  ops [6];
        logic [31:0] va  [6];
        logic [31:0] vb  [6];
        logic [31:0] ve  [6];
        logic [31:0] res, exp;
        int          lat;
        bit          hs_ok;
        ops = '{OP_DIV, OP_REMU, OP_DIV, OP_REM, OP_DIVU, OP_REM};
        va  = '{32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000, 32'd5, 32'hFFFF_FFF0};
        vb  = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0};
        ve  = '{32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFF0};
        for (int i = 0; i < 6; i++) begin
            exp_q.push_back(ve[i]);
            send_req(ops[i], va[i], vb[i]);
            wait_result(lat, res, hs_ok);
            exp = exp_q.pop_front();
            n_vec++; if (res !== exp) begin n_err++; $display("FAIL special[%0d] result: got %h want %h", i, res, exp); end
            n_vec++; if (lat !== 1) begin n_err++; $display("FAIL special[%0d] latency: got %0d want 1", i, lat); end
            n_vec++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL special[%0d] in_ready in done: got %b want 0", i, bus.in_ready); end
            consume();
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] res, exp;
        int          lat;
        bit          hs_ok;
        exp_q.push_back(32'hFFFF_FFEB);
        send_req(OP_MUL, 32'd7, 32'hFFFF_FFFD);
        wait_result(lat, res, hs_ok);
        exp = exp_q.pop_front();
        n_vec++; if (res !== exp) begin n_err++; $display("FAIL bp result: got %h want %h", res, exp); end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_vec++; if (bus.result !== exp) begin n_err++; $display("FAIL bp hold[%0d] result: got %h want %h", i, bus.result, exp); end
            n_vec++; if (bus.out_valid !== 1'b1) begin n_err++; $display("FAIL bp hold[%0d] out_valid: got %b want 1", i, bus.out_valid); end
            n_vec++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL bp hold[%0d] in_ready: got %b want 0", i, bus.in_ready); end
        end
        consume();
        n_vec++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL bp in_ready after take: got %b want 1", bus.in_ready); end
        n_vec++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL bp out_valid after take: got %b want 0", bus.out_valid); end
        exp_q.push_back(32'hFFFF_FFFE);
        send_req(OP_DIV, 32'hFFFF_FFEC, 32'd7);
        wait_result(lat, res, hs_ok);
        exp = exp_q.pop_front();
        n_vec++; if (res !== exp) begin n_err++; $display("FAIL b2b result: got %h want %h", res, exp); end
        n_vec++; if (lat !== 33) begin n_err++; $display("FAIL b2b latency: got %0d want 33", lat); end
        consume();
    endtask

    task automatic test_flush();
        logic [31:0] res, exp;
        int          lat;
        bit          hs_ok;
        bit          seen;
        send_req(OP_MUL, 32'h1234_5678, 32'h0000_5678);
        repeat (9) @(negedge clk);
        n_vec++; if (bus.busy !== 1'b1) begin n_err++; $display("FAIL flush busy before: got %b want 1", bus.busy); end
        bus.flush = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.flush = 1'b0;
        n_vec++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL flush in_ready: got %b want 1", bus.in_ready); end
        n_vec++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL flush out_valid: got %b want 0", bus.out_valid); end
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (bus.out_valid !== 1'b0) seen = 1'b1;
        end
        n_vec++; if (seen !== 1'b0) begin n_err++; $display("FAIL flush later out_valid: got 1 want 0"); end
        // Request coinciding with flush in IDLE must not be taken.
        bus.in_valid = 1'b1;
        bus.flush    = 1'b1;
        bus.op       = OP_DIVU;
        bus.a        = 32'd100;
        bus.b        = 32'd9;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.flush    = 1'b0;
        n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL flush idle busy: got %b want 0", bus.busy); end
        exp_q.push_back(32'd11);
        send_req(OP_DIVU, 32'd100, 32'd9);
        wait_result(lat, res, hs_ok);
        exp = exp_q.pop_front();
        n_vec++; if (res !== exp) begin n_err++; $display("FAIL flush next result: got %h want %h", res, exp); end
        n_vec++; if (lat !== 33) begin n_err++; $display("FAIL flush next latency: got %0d want 33", lat); end
        consume();
    endtask

    task automatic test_reset_done();
        logic [31:0] res;
        int          lat;
        bit          hs_ok;
        send_req(OP_DIV, 32'd5, 32'd0);
        wait_result(lat, res, hs_ok);
        n_vec++; if (bus.out_valid !== 1'b1) begin n_err++; $display("FAIL rst_done pre out_valid: got %b want 1", bus.out_valid); end
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        n_vec++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL rst_done out_valid: got %b want 0", bus.out_valid); end
        n_vec++; if (bus.result !== 32'h0) begin n_err++; $display("FAIL rst_done result: got %h want 00000000", bus.result); end
        n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL rst_done busy: got %b want 0", bus.busy); end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst   = 1'b1;
        test_reset();
        test_mul();
        test_div();
        test_special();
        test_back_to_back();
        test_flush();
        test_reset_done();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/rv32m_muldiv_unit.md
Name: rv32m_muldiv_unit

Overview:
Iterative RV32M multiply/divide unit that sits beside the single-cycle ALU in the execute stage. It takes operand pairs that the ALU cannot handle in one cycle (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU) and computes them over multiple cycles. The pipeline hands it operands through a valid/ready request port and collects the 32-bit result through a valid/ready response port. One operation is in flight at a time.

Parameters:
XLEN, 32, operand/result width; only 32 is supported (iteration counter is clog2(XLEN) bits).

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous, active-high reset
in_valid  in  1  request valid
in_ready  out  1  unit can accept a request (high only in IDLE)
op  in  3  RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
a  in  XLEN  rs1 operand
b  in  XLEN  rs2 operand
flush  in  1  abort any in-flight op (pipeline squash)
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
result  out  XLEN  operation result
busy  out  1  high in CALC or DONE

Behaviour:
- Reset (rst=1 at edge): state=IDLE, out_valid=0, result=0, busy=0, counter=0, all datapath registers cleared. Reset overrides flush and every handshake. Reset mid-CALC or mid-DONE discards the op.
- In IDLE, in_ready=1 (combinational from state). All other states hold in_ready=0.
- Accept: in_valid && in_ready at edge E0 latches op, |a|, |b|, sign info, and clears counter.
  - If the op is a divide-class op with b==0, or is DIV/REM with a==0x80000000 and b==0xFFFFFFFF, the unit goes to DONE with the special result.
  - Otherwise it goes to CALC.
- Multiply, CALC state: one shift-add step per cycle over a 64-bit accumulator.
  - The 64-bit product is negated when the operand signs differ.
  - MUL returns low 32 bits. MULH/MULHSU/MULHU return high 32 bits.
  - Signedness: MULH signed×signed; MULHSU a signed × b unsigned; MULHU unsigned×unsigned.
- Divide, CALC state: restoring division, one quotient bit per cycle.
  - DIV quotient sign = sign(a) XOR sign(b).
  - REM remainder sign = sign(a).
  - DIVU/REMU are unsigned.
- CALC runs exactly 32 cycles (counter 0..31). At the edge where counter==31 the unit moves to DONE and registers result.
- Latency: out_valid=1 exactly 33 cycles after E0 for the normal path, and 1 cycle after E0 for the special-case path.
- Special results:
  - Divide by zero: DIV/DIVU give 0xFFFFFFFF; REM/REMU give a.
  - Signed overflow: DIV gives 0x80000000; REM gives 0.
- DONE: out_valid=1. result is held stable while out_ready=0, for any number of cycles. On out_valid && out_ready the unit returns to IDLE and out_valid=0 next cycle. No new request is accepted in the same cycle.
- flush=1 at an edge in CALC or DONE: go to IDLE and drop the result. out_valid=0 next cycle.
  - flush has priority over the out handshake in the same cycle.
  - flush in IDLE blocks acceptance in that cycle.
- a, b and op are ignored except at the accept edge; input changes during CALC have no effect.
- No X on outputs after reset. result retains its last value in IDLE.

Decomposition:
- Shared package rv32m_pkg:
  - funct3 op localparams (OP_MUL..OP_REMU).
  - state encoding (ST_IDLE, ST_CALC, ST_DONE).
  - constants INT_MIN=0x80000000 and ALL_ONES=0xFFFFFFFF.
  - helper function is_div(op).
- One natural sub-module, rv32m_sign_cond (combinational):
  - pre-conditioning: absolute values and sign flags per op.
  - post-conditioning: conditional negation of the 64-bit product, quotient and remainder.
- FSM, counter and iteration datapath stay in the top module.

Test Plan:
- MUL a=7, b=0xFFFFFFFD (−3) → result 0xFFFFFFEB; out_valid exactly 33 cycles after accept; in_ready=0 throughout; busy=1.
- MULH 0x80000000×0x80000000 → 0x40000000; MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE; MULHSU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF; MUL 0xFFFFFFFF×0xFFFFFFFF → 0x00000001.
- DIV 0xFFFFFFEC (−20)/7 → 0xFFFFFFFE; REM same operands → 0xFFFFFFFA; DIVU 20/7 → 2; REMU 20/7 → 6.
- Special cases, each with out_valid 1 cycle after accept:
  - DIV 5/0 → 0xFFFFFFFF.
  - REMU 5/0 → 5.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000.
  - REM same operands → 0.
- Backpressure and back-to-back:
  - Hold out_ready=0 for 5 cycles in DONE → result and out_valid stable, in_ready=0.
  - Then out_ready=1 → in_ready=1 next cycle.
  - A second request issued immediately completes correctly.
- Abort:
  - flush at CALC cycle 10 → no out_valid ever, in_ready=1 next cycle, following DIVU 100/9 → 11.
  - rst mid-DONE → out_valid=0, result=0 after the edge.
